// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: raster counters, hsync/vsync generation and TMDS
// period sequencing (video preamble/guard/active, data-island preamble/guard/
// packet) for an HDMI transmitter.
// Build option: define HDMI_DATA_ISLAND_EN to include the data-island
// scheduler. Without it the block is a plain DVI timing source and every
// island-related output is tied low.
module hdmi_period_scheduler #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FRONT  = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BACK   = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FRONT  = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 20,
  parameter int SYNC_POL = 1,
  parameter int DI_GAP   = 4
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_pkt_valid,
  input  logic [8:0]  I_pkt_word,
  output logic        O_pkt_ack,
  output logic [4:0]  O_pkt_addr,
  output logic        O_hsync,
  output logic        O_vsync,
  output logic [11:0] O_x,
  output logic [11:0] O_y,
  output logic        O_video_preamble,
  output logic        O_video_guard,
  output logic        O_video_period,
  output logic        O_data_preamble,
  output logic        O_data_guard,
  output logic        O_data_period,
  output logic [8:0]  O_packet_data,
  output logic        O_packet_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] X_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] Y_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] X_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] Y_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic        SYNC_ON = (SYNC_POL != 0);

  // pos_* is the raster position of the cycle being computed; every output
  // register is loaded from it, so O_x/O_y and all period controls emerge
  // on the same edge and stay aligned.
  logic [11:0] pos_x_q, pos_x_d;
  logic [11:0] pos_y_q, pos_y_d;
  logic [11:0] x_q, y_q;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_period_q, video_period_d;
  logic        video_pre_q, video_pre_d;
  logic        video_guard_q, video_guard_d;

  // Raster position advance: x wraps at end of line, y steps on that wrap.
  always_comb begin
    pos_x_d = pos_x_q + 12'd1;
    pos_y_d = pos_y_q;
    if (pos_x_q == X_LAST) begin
      pos_x_d = '0;
      pos_y_d = (pos_y_q == Y_LAST) ? 12'd0 : pos_y_q + 12'd1;
    end
  end

`ifdef HDMI_DATA_ISLAND_EN
  localparam logic [11:0] Y_ACT_M1 = 12'(V_ACTIVE - 1);
  localparam logic [11:0] VPRE_BEG = 12'(H_TOTAL - 10);
  localparam logic [11:0] VGRD_BEG = 12'(H_TOTAL - 2);
  logic next_line_active;
`endif

  // Sync, active-video and video leading-edge decode for the current position.
  always_comb begin
    hsync_d = ((pos_x_q >= HS_BEG) && (pos_x_q < HS_END)) ? SYNC_ON : ~SYNC_ON;
    vsync_d = ((pos_y_q >= VS_BEG) && (pos_y_q < VS_END)) ? SYNC_ON : ~SYNC_ON;
    video_period_d = (pos_x_q < X_ACT) && (pos_y_q < Y_ACT);
`ifdef HDMI_DATA_ISLAND_EN
    // The preamble/guard lead into the following line, so they only appear
    // when that line carries video (including the wrap back to line 0).
    next_line_active = (pos_y_q < Y_ACT_M1) || (pos_y_q == Y_LAST);
    video_pre_d   = next_line_active && (pos_x_q >= VPRE_BEG) && (pos_x_q < VGRD_BEG);
    video_guard_d = next_line_active && (pos_x_q >= VGRD_BEG);
`else
    video_pre_d   = 1'b0;
    video_guard_d = 1'b0;
`endif
  end

  // Raster counters and timing outputs.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pos_x_q        <= '0;
      pos_y_q        <= '0;
      x_q            <= '0;
      y_q            <= '0;
      hsync_q        <= ~SYNC_ON;
      vsync_q        <= ~SYNC_ON;
      video_period_q <= 1'b0;
      video_pre_q    <= 1'b0;
      video_guard_q  <= 1'b0;
    end else begin
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      x_q            <= pos_x_q;
      y_q            <= pos_y_q;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      video_period_q <= video_period_d;
      video_pre_q    <= video_pre_d;
      video_guard_q  <= video_guard_d;
    end
  end

  assign O_x              = x_q;
  assign O_y              = y_q;
  assign O_hsync          = hsync_q;
  assign O_vsync          = vsync_q;
  assign O_video_period   = video_period_q;
  assign O_video_preamble = video_pre_q;
  assign O_video_guard    = video_guard_q;

`ifdef HDMI_DATA_ISLAND_EN
  // Decision point: the request is sampled on the edge that moves the
  // displayed x onto D, so the ack pulse is seen at x = D.
  localparam logic [11:0] DECIDE_X = 12'(H_ACTIVE + DI_GAP - 1);
  localparam bit          BLANK_OK = (H_TOTAL - H_ACTIVE) >= (DI_GAP + 44 + 12 + 10);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_LGUARD, ST_PACKET, ST_TGUARD
  } island_state_e;

  island_state_e state_q, state_d;
  logic [4:0] phase_q, phase_d;
  logic       ack_q, ack_d;
  logic       data_pre_q, data_pre_d;
  logic       data_guard_q, data_guard_d;
  logic       data_period_q, data_period_d;
  logic [4:0] addr_q, addr_d;
  logic       start_q, start_d;

  // Island sequencer: state_q describes the cycle now being computed,
  // phase_q counts cycles within the current period.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q + 5'd1;
    ack_d         = 1'b0;
    data_pre_d    = 1'b0;
    data_guard_d  = 1'b0;
    data_period_d = 1'b0;
    addr_d        = '0;
    start_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if ((pos_x_q == DECIDE_X) && I_pkt_valid) begin
          ack_d   = 1'b1;
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        data_pre_d = 1'b1;
        if (phase_q == 5'd7) begin
          state_d = ST_LGUARD;
          phase_d = '0;
        end
      end
      ST_LGUARD: begin
        data_guard_d = 1'b1;
        if (phase_q == 5'd1) begin
          state_d = ST_PACKET;
          phase_d = '0;
        end
      end
      ST_PACKET: begin
        data_period_d = 1'b1;
        addr_d        = phase_q;
        start_d       = (phase_q == 5'd0);
        if (phase_q == 5'd31) begin
          state_d = ST_TGUARD;
          phase_d = '0;
        end
      end
      ST_TGUARD: begin
        data_guard_d = 1'b1;
        if (phase_q == 5'd1) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Island state and registered island outputs; reset drops any island.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      ack_q         <= 1'b0;
      data_pre_q    <= 1'b0;
      data_guard_q  <= 1'b0;
      data_period_q <= 1'b0;
      addr_q        <= '0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      ack_q         <= ack_d;
      data_pre_q    <= data_pre_d;
      data_guard_q  <= data_guard_d;
      data_period_q <= data_period_d;
      addr_q        <= addr_d;
      start_q       <= start_d;
    end
  end

  assign O_pkt_ack       = ack_q;
  assign O_pkt_addr      = addr_q;
  assign O_data_preamble = data_pre_q;
  assign O_data_guard    = data_guard_q;
  assign O_data_period   = data_period_q;
  assign O_packet_start  = start_q;
  // The source answers the registered O_pkt_addr within the same cycle, so
  // the word is forwarded under the registered period flag to stay aligned
  // with O_pkt_addr and O_data_period.
  assign O_packet_data   = data_period_q ? I_pkt_word : 9'd0;

  // Configuration and exclusivity checks for simulation.
  always_ff @(posedge I_clk) begin
    if (I_rst_n) begin
      assert (BLANK_OK);
      assert ($onehot0({video_pre_q, video_guard_q, video_period_q,
                        data_pre_q, data_guard_q, data_period_q}));
    end
  end
`else
  logic dvi_unused;
  assign dvi_unused = ^{I_pkt_valid, I_pkt_word, 32'(DI_GAP)};

  assign O_pkt_ack       = 1'b0;
  assign O_pkt_addr      = 5'd0;
  assign O_data_preamble = 1'b0;
  assign O_data_guard    = 1'b0;
  assign O_data_period   = 1'b0;
  assign O_packet_start  = 1'b0;
  assign O_packet_data   = 9'd0;
`endif

endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Sequences the TMDS period controls for the HDMI output device.
- Runs the horizontal and vertical raster counters and generates hsync/vsync.
- Drives the video preamble, video guard and active video periods, plus the data-island preamble, guard and packet periods.
- Schedules at most one 32-word packet per line into horizontal blanking, on request from a packet source.
- Sits between the packet/pixel sources and the HDMI device. All outputs are registered and cycle-aligned with each other.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FRONT, 110, horizontal front porch
- H_SYNC, 40, hsync width
- H_BACK, 220, horizontal back porch
- V_ACTIVE, 720, active lines
- V_FRONT, 5, vertical front porch
- V_SYNC, 5, vsync width
- V_BACK, 20, vertical back porch
- SYNC_POL, 1, sync polarity; 1 = active-high hsync/vsync
- DI_GAP, 4, control cycles between end of active video and start of the data-island preamble

Ports:
- I_clk  in  1  pixel clock
- I_rst_n  in  1  asynchronous active-low reset
- I_pkt_valid  in  1  packet source has a packet pending
- I_pkt_word  in  9  packet word at O_pkt_addr, valid in the same cycle
- O_pkt_ack  out  1  one-cycle pulse: packet accepted for this line
- O_pkt_addr  out  5  packet word index 0..31
- O_hsync, O_vsync  out  1 each  sync outputs, polarity per SYNC_POL
- O_x, O_y  out  12 each  raster counters
- O_video_preamble, O_video_guard, O_video_period  out  1 each  video period controls
- O_data_preamble, O_data_guard, O_data_period  out  1 each  data-island period controls
- O_packet_data  out  9  packet word forwarded to the device
- O_packet_start  out  1  high on packet word 0 only

Behaviour:
- Counters and totals:
  - H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
  - O_x counts 0..H_TOTAL-1 and wraps to 0; O_y increments on that wrap and wraps to 0 at V_TOTAL-1.
- Reset: all counters 0, every period/strobe/data output 0, syncs at inactive level. Reset mid-line aborts any island at once; no partial packet resumes.
- Active video: O_video_period = 1 when x < H_ACTIVE and y < V_ACTIVE.
- Sync timing:
  - hsync active for x in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vsync active for y in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC), changing at x = 0.
- Video leading edge: applies only when the next line is active (y+1 < V_ACTIVE, or y = V_TOTAL-1).
  - O_video_preamble for x in [H_TOTAL-10, H_TOTAL-2).
  - O_video_guard for x in [H_TOTAL-2, H_TOTAL).
- Island state machine, states IDLE, PRE, LGUARD, PACKET, TGUARD:
  - Decision point D = H_ACTIVE+DI_GAP-1, evaluated on every line including vertical blanking.
  - IDLE: at x = D with I_pkt_valid = 1, pulse O_pkt_ack for 1 cycle and go to PRE. Otherwise stay in IDLE; I_pkt_valid is ignored at all other cycles.
  - PRE: 8 cycles, O_data_preamble = 1.
  - LGUARD: 2 cycles, O_data_guard = 1.
  - PACKET: 32 cycles, O_data_period = 1, O_pkt_addr = 0..31, O_packet_data = I_pkt_word (registered with the other outputs), O_packet_start = 1 when addr = 0.
  - TGUARD: 2 cycles, O_data_guard = 1, then back to IDLE.
- O_pkt_addr holds 0 outside PACKET. The source must keep the packet stable from ack until TGUARD ends; deasserting I_pkt_valid after ack has no effect.
- Blanking budget: H_TOTAL-H_ACTIVE ≥ DI_GAP+44+12+10. Violation is a configuration error; the island must never overlap the video preamble. This is checked by simulation assertion.
- At most one of the six period outputs is high in any cycle.

Optional Feature:
- HDMI_DATA_ISLAND_EN.
- Defined: behaviour as above.
- Undefined (DVI mode): island FSM removed; O_data_*, O_video_preamble, O_video_guard, O_packet_* and O_pkt_ack are tied 0; O_pkt_addr is tied 0; timing and O_video_period are unchanged.

Test Plan:
- Reset release, defaults, no packets -> O_video_period high x 0..1279 on y 0..719; hsync high x 1390..1429; vsync high y 725..729; video preamble x 1640..1647 and guard 1648..1649 on y 0..718 and y 749, absent on y 719..748.
- I_pkt_valid held high, defaults -> ack at x 1283; preamble 1284..1291; guard 1292..1293; packet 1294..1325 with addr 0..31 and start only at 1294; guard 1326..1327; repeats every line including y 730.
- I_pkt_valid rising at x 1284 -> no island that line; ack at x 1283 of the next line.
- Source returns word = addr+0x100 -> O_packet_data 0x100..0x11F over cycles 1294..1325, in order.
- Assert I_rst_n low at x 1300 mid-packet, release 5 cycles later -> all outputs 0 at once; counters restart at 0,0; next island at x 1283 of line 0.
- Build without HDMI_DATA_ISLAND_EN, I_pkt_valid high -> O_pkt_ack, O_data_* and preamble/guard stay 0 for a full frame; sync and video timing identical to the first scenario.
